// File: rtl/mc_alu_pkg.sv
// Shared opcode set and controller state encodings for the multi-cycle ALU.
package mc_alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_CMP = 6'h02;
    localparam logic [5:0] OP_AND = 6'h03;
    localparam logic [5:0] OP_OR  = 6'h04;
    localparam logic [5:0] OP_XOR = 6'h05;
    localparam logic [5:0] OP_TST = 6'h06;
    localparam logic [5:0] OP_NOT = 6'h07;
    localparam logic [5:0] OP_LSL = 6'h08;
    localparam logic [5:0] OP_LSR = 6'h09;
    localparam logic [5:0] OP_RSL = 6'h0A;
    localparam logic [5:0] OP_RSR = 6'h0B;
    localparam logic [5:0] OP_MUL = 6'h0C;
    localparam logic [5:0] OP_DIV = 6'h0D;
    localparam logic [5:0] OP_MOD = 6'h0E;

    typedef enum logic [1:0] {
        MC_ALU_IDLE = 2'd0,
        MC_ALU_BUSY = 2'd1,
        MC_ALU_DONE = 2'd2
    } mc_alu_state_t;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative one-bit-per-cycle engine: unsigned shift-add multiply and restoring divide.
module mc_alu_muldiv #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_reg, mq_reg, opnd_reg;
    logic [SHW-1:0]   cnt_reg;
    logic             busy_reg, mul_reg;
    logic [WIDTH:0]   add_sum, rem_wide, trial;

    // acc:mq is the double-width product (MUL) or remainder:quotient (DIV/MOD)
    always_comb begin
        add_sum  = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, opnd_reg} : '0);
        rem_wide = {acc_reg, mq_reg[WIDTH-1]};
        trial    = rem_wide - {1'b0, opnd_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            mq_reg   <= '0;
            opnd_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            mul_reg  <= 1'b0;
        end else if (start) begin
            acc_reg  <= '0;
            mq_reg   <= a;
            opnd_reg <= b;
            cnt_reg  <= SHW'(WIDTH - 1);
            busy_reg <= 1'b1;
            mul_reg  <= is_mul;
        end else if (busy_reg) begin
            if (mul_reg) begin
                {acc_reg, mq_reg} <= {add_sum, mq_reg[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
                acc_reg <= trial[WIDTH-1:0];
                mq_reg  <= {mq_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_reg <= {acc_reg[WIDTH-2:0], mq_reg[WIDTH-1]};
                mq_reg  <= {mq_reg[WIDTH-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done = busy_reg && (cnt_reg == '0);
    assign hi   = acc_reg;
    assign lo   = mq_reg;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: handshake FSM, single-cycle datapath, flag generation and output registers.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int MSB = WIDTH - 1;

    mc_alu_state_t    state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [5:0]       op_reg;
    logic             accept, long_op;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   shl_wide, shr_wide;
    logic [WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0] res_next;
    logic             c_next, v_next, dz_next, ill_next;

    assign in_ready = (state_reg == MC_ALU_IDLE);
    assign accept   = in_valid && in_ready;
    // b = 0 never needs the iterative engine: MUL is 0, DIV/MOD are fixed values
    assign long_op  = is_muldiv(opcode) && (b != '0);

    mc_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && long_op),
        .is_mul (opcode == OP_MUL),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MC_ALU_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg  <= a;
                b_reg  <= b;
                op_reg <= opcode;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MC_ALU_IDLE: if (accept) state_next = long_op ? MC_ALU_BUSY : MC_ALU_DONE;
            MC_ALU_BUSY: if (md_done) state_next = MC_ALU_DONE;
            MC_ALU_DONE: if (out_valid && out_ready) state_next = MC_ALU_IDLE;
            default:     state_next = MC_ALU_IDLE;
        endcase
    end

    assign shamt    = b_reg[SHW-1:0];
    assign shl_wide = {1'b0, a_reg} << shamt;
    assign shr_wide = {a_reg, 1'b0} >> shamt;

    // Index arithmetic wraps modulo WIDTH because WIDTH is a power of two
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        assign rot_l[gi] = a_reg[SHW'(gi) - shamt];
        assign rot_r[gi] = a_reg[SHW'(gi) + shamt];
    end

    always_comb begin
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        dz_next  = 1'b0;
        ill_next = 1'b0;
        case (op_reg)
            OP_ADD: begin
                {c_next, res_next} = {1'b0, a_reg} + {1'b0, b_reg};
                v_next = (a_reg[MSB] == b_reg[MSB]) && (res_next[MSB] != a_reg[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res_next = a_reg - b_reg;
                c_next   = a_reg < b_reg;
                v_next   = (a_reg[MSB] != b_reg[MSB]) && (res_next[MSB] != a_reg[MSB]);
            end
            OP_AND, OP_TST: res_next = a_reg & b_reg;
            OP_OR:  res_next = a_reg | b_reg;
            OP_XOR: res_next = a_reg ^ b_reg;
            OP_NOT: res_next = ~a_reg;
            OP_LSL: {c_next, res_next} = shl_wide;
            OP_LSR: {res_next, c_next} = shr_wide;
            OP_RSL: res_next = rot_l;
            OP_RSR: res_next = rot_r;
            OP_MUL: begin
                if (b_reg != '0) begin
                    res_next = md_lo;
                    c_next   = |md_hi;
                    v_next   = |md_hi;
                end
            end
            OP_DIV: begin
                dz_next  = (b_reg == '0);
                res_next = dz_next ? '1 : md_lo;
            end
            OP_MOD: begin
                dz_next  = (b_reg == '0);
                res_next = dz_next ? a_reg : md_hi;
            end
            default: ill_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (state_reg == MC_ALU_DONE && !out_valid) begin
            out_valid   <= 1'b1;
            result      <= res_next;
            zero        <= (res_next == '0);
            negative    <= res_next[MSB];
            carry       <= c_next;
            overflow    <= v_next;
            div_by_zero <= dz_next;
            illegal_op  <= ill_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Randomised and directed bench for mc_alu against an arithmetic reference model.
module tb_mc_alu;
    import mc_alu_pkg::*;

    localparam int W   = 16;
    localparam int SHW = $clog2(W);

    typedef struct packed {
        logic [W-1:0] res;
        logic z, n, c, v, dz, ill;
    } flags_t;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a, b, res;
        logic [5:0]  fl;
        int          lat;
    } dir_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0, result;
    logic [5:0]   opcode = '0;
    logic         zero, negative, carry, overflow, div_by_zero, illegal_op;
    int           errors = 0, checks = 0, cyc = 0;

    mc_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dir_t tbl [13] = '{
        '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 6'b010100, 1},
        '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 6'b101100, 17},
        '{OP_MUL, 16'h0004, 16'h0003, 16'h000C, 6'b000000, 17},
        '{OP_DIV, 16'h000F, 16'h0003, 16'h0005, 6'b000000, 17},
        '{OP_MOD, 16'h000F, 16'h0004, 16'h0003, 6'b000000, 17},
        '{OP_DIV, 16'h0010, 16'h0000, 16'hFFFF, 6'b010010, 1},
        '{OP_LSL, 16'h8001, 16'h0001, 16'h0002, 6'b001000, 1},
        '{OP_LSR, 16'h8000, 16'h000F, 16'h0001, 6'b000000, 1},
        '{OP_RSL, 16'h8001, 16'h0004, 16'h0018, 6'b000000, 1},
        '{OP_LSL, 16'h1234, 16'h0000, 16'h1234, 6'b000000, 1},
        '{OP_RSR, 16'h0001, 16'h0001, 16'h8000, 6'b010000, 1},
        '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 6'b011000, 1},
        '{6'h3F,  16'h0001, 16'h0002, 16'h0000, 6'b100001, 1}
    };

    function automatic longint sgn(input longint unsigned x);
        return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    endfunction

    // Reference model: plain integer arithmetic on 64-bit values
    function automatic flags_t model(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint unsigned ua = av, ub = bv, full = 64'd1 << W, r = 0, p;
        longint ss, half = longint'(1) << (W - 1);
        int n = int'(ub % W);
        flags_t f = '0;
        case (op)
            OP_ADD: begin
                r = ua + ub; f.c = (r >= full);
                ss = sgn(ua) + sgn(ub); f.v = (ss >= half) || (ss < -half);
            end
            OP_SUB, OP_CMP: begin
                r = ua + full - ub; f.c = (ua < ub);
                ss = sgn(ua) - sgn(ub); f.v = (ss >= half) || (ss < -half);
            end
            OP_AND, OP_TST: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOT: r = ~ua;
            OP_LSL: begin r = ua << n; f.c = (n != 0) && (((ua >> (W - n)) & 1) != 0); end
            OP_LSR: begin r = ua >> n; f.c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            OP_RSL: r = (n == 0) ? ua : ((ua << n) | (ua >> (W - n)));
            OP_RSR: r = (n == 0) ? ua : ((ua >> n) | (ua << (W - n)));
            OP_MUL: begin p = ua * ub; r = p; f.c = (p >> W) != 0; f.v = f.c; end
            OP_DIV: begin f.dz = (ub == 0); r = f.dz ? full - 1 : ua / ub; end
            OP_MOD: begin f.dz = (ub == 0); r = f.dz ? ua : ua % ub; end
            default: begin f.ill = 1'b1; r = 0; end
        endcase
        r = r & (full - 1);
        f.res = r[W-1:0];
        f.z = (f.res == '0);
        f.n = f.res[W-1];
        return f;
    endfunction

    function automatic flags_t observe();
        return {result, zero, negative, carry, overflow, div_by_zero, illegal_op};
    endfunction

    // Handshake an operation in, scramble inputs after accept, wait for out_valid
    task automatic issue(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output bit to, output int acc_cyc);
        int guard = 0;
        to = 1'b0; lat = 0; acc_cyc = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!in_ready) begin to = 1'b1; return; end
        opcode = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0; opcode = 6'($urandom); a = W'($urandom); b = W'($urandom);
        while (!out_valid && lat < 4 * W) begin @(posedge clk); lat++; #1; end
        if (!out_valid) to = 1'b1;
        $display("txn op=%02h a=%h b=%h -> result=%h lat=%0d", op, av, bv, result, lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, observe()} !== {1'b1, 1'b0, flags_t'(0)}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b outs=%h want rdy=1 vld=0 outs=0", in_ready, out_valid, observe());
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat, ac; bit to; flags_t o;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, to, ac);
            o = observe();
            checks++;
            if (to || {o.res, o.z, o.n, o.c, o.v, o.dz, o.ill} !== {tbl[i].res, tbl[i].fl}) begin
                errors++;
                $display("FAIL directed_%0d: got res=%h fl=%b to=%b want res=%h fl=%b", i, o.res,
                         {o.z, o.n, o.c, o.v, o.dz, o.ill}, to, tbl[i].res, tbl[i].fl);
            end
            checks++;
            if (lat != tbl[i].lat) begin
                errors++;
                $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, tbl[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_random();
        int lat, ac, r, exp_lat; bit to; logic [5:0] op; logic [W-1:0] av, bv; flags_t e, o;
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 19);
            op = (r < 15) ? 6'(r) : 6'($urandom_range(15, 63));
            av = W'($urandom);
            bv = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if (op == OP_LSL || op == OP_LSR || op == OP_RSL || op == OP_RSR) bv = W'($urandom_range(0, W - 1));
            e = model(op, av, bv);
            exp_lat = (is_muldiv(op) && bv != '0) ? W + 1 : 1;
            issue(op, av, bv, lat, to, ac);
            o = observe();
            checks++;
            if (to || o !== e || lat != exp_lat) begin
                errors++;
                $display("FAIL random_%0d op=%02h a=%h b=%h: got %h lat=%0d want %h lat=%0d", i, op, av, bv,
                         o, lat, e, exp_lat);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat, ac, prev = 0; bit to; logic [W-1:0] av, bv; flags_t e;
        for (int i = 0; i < 8; i++) begin
            av = W'($urandom); bv = W'($urandom);
            e = model(OP_XOR, av, bv);
            issue(OP_XOR, av, bv, lat, to, ac);
            checks++;
            if (to || observe() !== e) begin
                errors++;
                $display("FAIL b2b_result_%0d: got %h want %h", i, observe(), e);
            end
            if (i > 0) begin
                checks++;
                if (ac - prev != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d want 3", i, ac - prev);
                end
            end
            prev = ac;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat, ac; bit to;
        issue(OP_SUB, W'(5), W'(3), lat, to, ac);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (to || result !== W'(2) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got res=%h vld=%b rdy=%b want res=0002 vld=1 rdy=0", i, result, out_valid, in_ready);
            end
            @(posedge clk);
            #1;
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_early_ready();
        int lat, ac; bit to;
        out_ready = 1'b1;
        issue(OP_MUL, W'(7), W'(9), lat, to, ac);
        checks++;
        if (to || result !== W'(63) || lat != W + 1) begin
            errors++;
            $display("FAIL early_ready: got res=%h lat=%0d want res=003f lat=%0d", result, lat, W + 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_ready_done: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat, ac; bit to;
        @(negedge clk);
        opcode = OP_DIV; a = W'(16'h1234); b = W'(7); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, observe()} !== {1'b1, 1'b0, flags_t'(0)}) begin
            errors++;
            $display("FAIL reset_mid_div: got rdy=%b vld=%b outs=%h want rdy=1 vld=0 outs=0", in_ready, out_valid, observe());
        end
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: got vld=%b want 0", out_valid);
        end
        issue(OP_ADD, W'(5), W'(3), lat, to, ac);
        checks++;
        if (to || result !== W'(8) || lat != 1) begin
            errors++;
            $display("FAIL reset_then_add: got res=%h lat=%0d want res=0008 lat=1", result, lat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_early_ready();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
